// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg : shared ALU op codes and issue-controller state type     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } issue_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_settle_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_settle_cnt : loadable down-counter with a zero flag           |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module alu_settle_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_issue_ctrl : request/response issue controller for the ALU    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_acc,
  input  logic        clr_flags,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [1:0]  alu_aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_z,
  input  logic        alu_v,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_r,
  output logic        rsp_z,
  output logic        rsp_v,
  output logic [31:0] acc,
  output logic        sticky_v
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  issue_state_t state, state_nxt;
  logic             accept;
  logic             capture;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt;
  logic             clr_pend;

  assign accept  = req_valid && req_ready;
  assign capture = (state == ISSUE) && cnt_zero;

  alu_settle_cnt #(
    .CNT_W (CNT_W)
  ) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (SETTLE_LOAD),
    .dec      (state == ISSUE),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = ISSUE;
      ISSUE:   if (cnt_zero)  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered decodes of the next state, so req_ready
  // stays low throughout reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_x    <= '0;
      alu_y    <= '0;
      alu_aluc <= ALU_ADD;
    end else if (accept) begin
      alu_x    <= req_acc ? acc : req_a;
      alu_y    <= req_b;
      alu_aluc <= req_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_r <= '0;
      rsp_z <= 1'b0;
      rsp_v <= 1'b0;
    end else if (capture) begin
      rsp_r <= alu_r;
      rsp_z <= alu_z;
      rsp_v <= alu_v;
    end
  end

  // A clear seen during ISSUE is held and lands at capture, overriding it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_pend <= 1'b0;
      acc      <= '0;
      sticky_v <= 1'b0;
    end else begin
      if (capture) begin
        clr_pend <= 1'b0;
        if (clr_pend || clr_flags) begin
          acc      <= '0;
          sticky_v <= 1'b0;
        end else begin
          acc      <= alu_r;
          sticky_v <= sticky_v | alu_v;
        end
      end else if (state == ISSUE) begin
        if (clr_flags) clr_pend <= 1'b1;
      end else if (clr_flags) begin
        acc      <= '0;
        sticky_v <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_issue_ctrl : randomized self-checking bench with ALU model |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        req_acc = 1'b0;
  logic        clr_flags = 1'b0;
  logic [31:0] alu_x, alu_y, alu_r;
  logic [1:0]  alu_aluc;
  logic        alu_z, alu_v;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_r, acc;
  logic        rsp_z, rsp_v, sticky_v;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_acc = '0;
  logic        m_sticky = 1'b0;

  alu_issue_ctrl #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_acc(req_acc),
    .clr_flags(clr_flags), .alu_x(alu_x), .alu_y(alu_y), .alu_aluc(alu_aluc),
    .alu_r(alu_r), .alu_z(alu_z), .alu_v(alu_v), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_r(rsp_r), .rsp_z(rsp_z), .rsp_v(rsp_v),
    .acc(acc), .sticky_v(sticky_v)
  );

  // Combinational ALU that sits above the controller.
  always_comb begin
    alu_r = '0;
    alu_v = 1'b0;
    case (alu_aluc)
      ALU_ADD: begin
        alu_r = alu_x + alu_y;
        alu_v = (alu_x[31] == alu_y[31]) && (alu_r[31] != alu_x[31]);
      end
      ALU_SUB: begin
        alu_r = alu_x - alu_y;
        alu_v = (alu_x[31] != alu_y[31]) && (alu_r[31] != alu_x[31]);
      end
      ALU_AND: alu_r = alu_x & alu_y;
      default: alu_r = alu_x | alu_y;
    endcase
    alu_z = (alu_r == '0);
  end

  always #5 clk = ~clk;

  // Transaction-level reference: signed math in 64 bits, then update acc/sticky.
  task automatic model_step(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic use_acc, input logic clr,
                            output logic [31:0] er, output logic ez, output logic ev,
                            output logic [31:0] ex);
    longint sx, sy, wide;
    ex = use_acc ? m_acc : a;
    sx = longint'($signed(ex));
    sy = longint'($signed(b));
    ev = 1'b0;
    case (op)
      2'd0: begin wide = sx + sy; er = wide[31:0]; ev = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      2'd1: begin wide = sx - sy; er = wide[31:0]; ev = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      2'd2: er = ex & b;
      default: er = ex | b;
    endcase
    ez = (er == 32'd0);
    if (clr) begin
      m_acc = '0;
      m_sticky = 1'b0;
    end else begin
      m_acc = er;
      m_sticky = m_sticky | ev;
    end
  endtask

  // Drives one request and returns at a negedge with the response presented.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_acc, input logic clr_issue, input int stall,
                        input logic [31:0] ex, output int lat, output logic ops_ok,
                        output logic held_ok);
    int w;
    logic [31:0] hold_r;
    lat = -1; ops_ok = 1'b1; held_ok = 1'b1; w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (!req_ready) return;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_acc = use_acc;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'($urandom); req_a = $urandom; req_b = $urandom;
    req_op = 2'($urandom); req_acc = 1'($urandom); clr_flags = clr_issue;
    rsp_ready = 1'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      if (alu_x !== ex || alu_y !== b || alu_aluc !== op) ops_ok = 1'b0;
      @(posedge clk); lat++;
      @(negedge clk);
      clr_flags = 1'b0;
    end
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    hold_r = rsp_r;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!rsp_valid || rsp_r !== hold_r || req_ready !== 1'b0 || alu_x !== ex) held_ok = 1'b0;
    end
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp(output logic done_ok);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    done_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
  endtask

  task automatic test_reset();
    logic [31:0] er, ex; logic ez, ev, ok, held, done; int lat;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if ({req_ready, rsp_valid, rsp_r, rsp_z, rsp_v, acc, sticky_v, alu_x, alu_y, alu_aluc} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {req_ready, rsp_valid, rsp_r, rsp_z, rsp_v, acc, sticky_v, alu_x, alu_y, alu_aluc}); end
    rst = 1'b0; #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_pre_edge: got %b expected 0", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ready_post_edge: got ready=%b valid=%b expected 1/0", req_ready, rsp_valid); end
    m_acc = '0; m_sticky = 1'b0;
    model_step(ALU_ADD, 32'h0000_1234, 32'd5, 1'b1, 1'b0, er, ez, ev, ex);
    run_op(ALU_ADD, 32'h0000_1234, 32'd5, 1'b1, 1'b0, 0, ex, lat, ok, held);
    checks++; if (rsp_r !== er || alu_x !== 32'd0) begin
      errors++; $display("FAIL first_acc_zero: got r=%h x=%h expected r=%h x=0", rsp_r, alu_x, er); end
    finish_rsp(done);
    checks++; if (!done) begin errors++; $display("FAIL first_acc_done: got 0 expected 1"); end
  endtask

  task automatic test_arith();
    logic [1:0]  ops [6];
    logic [31:0] av [6];
    logic [31:0] bv [6];
    logic [31:0] er, ex; logic ez, ev, ok, held, done; int lat;
    ops = '{ALU_ADD, ALU_SUB, ALU_SUB, ALU_AND, ALU_OR, ALU_ADD};
    av  = '{32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_FFFF};
    bv  = '{32'd1, 32'd5, 32'd1, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'd1};
    for (int i = 0; i < 6; i++) begin
      model_step(ops[i], av[i], bv[i], 1'b0, 1'b0, er, ez, ev, ex);
      run_op(ops[i], av[i], bv[i], 1'b0, 1'b0, 0, ex, lat, ok, held);
      checks++; if (lat !== S) begin errors++; $display("FAIL arith_latency[%0d]: got %0d expected %0d", i, lat, S); end
      checks++; if (rsp_r !== er) begin errors++; $display("FAIL arith_r[%0d]: got %h expected %h", i, rsp_r, er); end
      checks++; if (rsp_z !== ez || rsp_v !== ev) begin
        errors++; $display("FAIL arith_zv[%0d]: got z=%b v=%b expected z=%b v=%b", i, rsp_z, rsp_v, ez, ev); end
      checks++; if (acc !== m_acc || sticky_v !== m_sticky) begin
        errors++; $display("FAIL arith_acc[%0d]: got acc=%h st=%b expected acc=%h st=%b", i, acc, sticky_v, m_acc, m_sticky); end
      checks++; if (!ok) begin errors++; $display("FAIL arith_operands[%0d]: got unstable expected stable", i); end
      finish_rsp(done);
      checks++; if (!done) begin errors++; $display("FAIL arith_done[%0d]: got 0 expected 1", i); end
    end
  endtask

  task automatic test_accumulate();
    logic [31:0] er, ex; logic ez, ev, ok, held, done; int lat;
    model_step(ALU_ADD, 32'd3, 32'd4, 1'b0, 1'b0, er, ez, ev, ex);
    run_op(ALU_ADD, 32'd3, 32'd4, 1'b0, 1'b0, 0, ex, lat, ok, held);
    checks++; if (rsp_r !== er) begin errors++; $display("FAIL acc_first: got %h expected %h", rsp_r, er); end
    finish_rsp(done);
    model_step(ALU_ADD, 32'h0000_DEAD, 32'd10, 1'b1, 1'b0, er, ez, ev, ex);
    run_op(ALU_ADD, 32'h0000_DEAD, 32'd10, 1'b1, 1'b0, 0, ex, lat, ok, held);
    checks++; if (rsp_r !== er || acc !== m_acc) begin
      errors++; $display("FAIL acc_chain: got r=%h acc=%h expected %h", rsp_r, acc, er); end
    checks++; if (!ok) begin errors++; $display("FAIL acc_operands: got unstable expected stable"); end
    finish_rsp(done);
  endtask

  task automatic test_backpressure_clear();
    logic [31:0] er, ex; logic ez, ev, ok, held, done; int lat;
    model_step(ALU_SUB, 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0, er, ez, ev, ex);
    run_op(ALU_SUB, 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0, 20, ex, lat, ok, held);
    checks++; if (!held) begin errors++; $display("FAIL bp_hold: got unstable expected frozen"); end
    checks++; if (rsp_r !== er) begin errors++; $display("FAIL bp_r: got %h expected %h", rsp_r, er); end
    finish_rsp(done);
    checks++; if (!done) begin errors++; $display("FAIL bp_done: got 0 expected 1"); end
    model_step(ALU_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, er, ez, ev, ex);
    run_op(ALU_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 0, ex, lat, ok, held);
    checks++; if (acc !== 32'd0 || sticky_v !== 1'b0) begin
      errors++; $display("FAIL clr_in_issue: got acc=%h st=%b expected 0/0", acc, sticky_v); end
    checks++; if (rsp_r !== er || rsp_v !== ev) begin
      errors++; $display("FAIL clr_capture: got r=%h v=%b expected r=%h v=%b", rsp_r, rsp_v, er, ev); end
    finish_rsp(done);
    model_step(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, er, ez, ev, ex);
    run_op(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 0, ex, lat, ok, held);
    finish_rsp(done);
    clr_flags = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_flags = 1'b0;
    m_acc = '0; m_sticky = 1'b0;
    checks++; if (acc !== m_acc || sticky_v !== m_sticky) begin
      errors++; $display("FAIL clr_in_idle: got acc=%h st=%b expected 0/0", acc, sticky_v); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] er, ex; logic ez, ev, ok, held, done, seen; int lat;
    req_valid = 1'b1; req_op = ALU_ADD; req_a = 32'h7FFF_FFFF; req_b = 32'd1; req_acc = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if ({req_ready, rsp_valid, rsp_r, rsp_z, rsp_v, acc, sticky_v, alu_x, alu_y, alu_aluc} !== '0) begin
      errors++; $display("FAIL midop_async_reset: got %h expected 0", {req_ready, rsp_valid, rsp_r, rsp_z, rsp_v, acc, sticky_v, alu_x, alu_y, alu_aluc}); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    m_acc = '0; m_sticky = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || acc !== 32'd0 || sticky_v) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midop_no_response: got activity expected none"); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midop_ready: got %b expected 1", req_ready); end
    model_step(ALU_ADD, 32'd1, 32'd1, 1'b0, 1'b0, er, ez, ev, ex);
    run_op(ALU_ADD, 32'd1, 32'd1, 1'b0, 1'b0, 0, ex, lat, ok, held);
    checks++; if (rsp_r !== er || lat !== S) begin
      errors++; $display("FAIL midop_recover: got r=%h lat=%0d expected r=%h lat=%0d", rsp_r, lat, er, S); end
    finish_rsp(done);
  endtask

  task automatic test_random();
    logic [31:0] corner [5];
    logic [31:0] a, b, er, ex; logic [1:0] op; logic use_acc, clr, ez, ev, ok, held, done; int lat, stall;
    corner = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      use_acc = 1'($urandom);
      clr = ($urandom_range(0, 3) == 0);
      stall = $urandom_range(0, 3);
      model_step(op, a, b, use_acc, clr, er, ez, ev, ex);
      run_op(op, a, b, use_acc, clr, stall, ex, lat, ok, held);
      checks++; if (lat !== S) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, S); end
      checks++; if ({rsp_r, rsp_z, rsp_v} !== {er, ez, ev}) begin
        errors++; $display("FAIL rand_rsp[%0d]: got %h/%b/%b expected %h/%b/%b", i, rsp_r, rsp_z, rsp_v, er, ez, ev); end
      checks++; if (acc !== m_acc || sticky_v !== m_sticky) begin
        errors++; $display("FAIL rand_acc[%0d]: got acc=%h st=%b expected acc=%h st=%b", i, acc, sticky_v, m_acc, m_sticky); end
      checks++; if (!ok || !held) begin errors++; $display("FAIL rand_stable[%0d]: got ops=%b held=%b expected 1/1", i, ok, held); end
      finish_rsp(done);
      checks++; if (!done) begin errors++; $display("FAIL rand_done[%0d]: got 0 expected 1", i); end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_accumulate();
    test_backpressure_clear();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
